// File: rtl/delta_calc_arbiter.sv
// delta_calc_arbiter
//   Round-robin arbiter that shares one angle-delta calculator between four
//   wheels. A granted wheel's target/current angles are latched and presented
//   to the calculator. The calculator result, or a timeout error, is captured.
//   The served wheel then receives a one-cycle grant_done pulse.
//
// Ports
//   clock, reset         : main clock, synchronous active-high reset
//   req[3:0]             : per-wheel request level
//   target_angle_flat    : wheel i target angle at [12i+11:12i]
//   current_angle_flat   : wheel i encoder angle at [12i+11:12i]
//   calc_enable          : one-cycle start pulse to the calculator
//   calc_target/current  : angles held stable for the calculator
//   calc_delta/dir       : calculator result, valid with calc_updated
//   calc_updated         : calculator one-cycle valid pulse
//   grant_done[3:0]      : one-hot completion pulse to the served wheel
//   result_delta/dir/err : result of the last completed transaction
//   busy                 : high whenever the arbiter is not idle
module delta_calc_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [47:0] target_angle_flat,
  input  logic [47:0] current_angle_flat,
  output logic        calc_enable,
  output logic [11:0] calc_target,
  output logic [11:0] calc_current,
  input  logic [11:0] calc_delta,
  input  logic        calc_dir,
  input  logic        calc_updated,
  output logic [3:0]  grant_done,
  output logic [11:0] result_delta,
  output logic        result_dir,
  output logic        result_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic [1:0] grant_idx;
  logic [1:0] last_grant;
  logic [4:0] wait_cnt;
  logic [1:0] rr_idx;
  logic [1:0] cand;

  // The search runs descending, so the last hit kept is the closest wheel
  // after last_grant. When k is 4, the candidate wraps back to last_grant itself.
  always_comb begin
    // NOTE: default first so every path assigns rr_idx and no latch is inferred.
    rr_idx = last_grant;
    cand   = last_grant;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (req[cand]) rr_idx = cand;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: non-blocking throughout so every register updates from pre-edge values.
      state        <= IDLE;
      grant_idx    <= 2'd0;
      last_grant   <= 2'd3;
      wait_cnt     <= 5'd0;
      calc_enable  <= 1'b0;
      calc_target  <= 12'd0;
      calc_current <= 12'd0;
      grant_done   <= 4'd0;
      result_delta <= 12'd0;
      result_dir   <= 1'b0;
      result_err   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant_idx    <= rr_idx;
            calc_target  <= target_angle_flat[12*rr_idx +: 12];
            calc_current <= current_angle_flat[12*rr_idx +: 12];
            calc_enable  <= 1'b1;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          calc_enable <= 1'b0;
          wait_cnt    <= 5'd0;
          state       <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 5'd1;
          // calc_updated is tested first so a response on the final WAIT
          // cycle is still accepted rather than reported as a timeout.
          if (calc_updated) begin
            result_delta <= calc_delta;
            result_dir   <= calc_dir;
            result_err   <= 1'b0;
            grant_done   <= 4'b0001 << grant_idx;
            state        <= DONE;
          end else if (wait_cnt == 5'(TIMEOUT_CYCLES - 1)) begin
            result_delta <= 12'd0;
            result_dir   <= 1'b0;
            result_err   <= 1'b1;
            grant_done   <= 4'b0001 << grant_idx;
            state        <= DONE;
          end
        end
        DONE: begin
          grant_done <= 4'd0;
          last_grant <= grant_idx;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delta_calc_arbiter.sv
// tb_delta_calc_arbiter
//   Directed bench for delta_calc_arbiter. A calculator model replies a set
//   number of cycles after it sees calc_enable. Outputs are sampled on the
//   falling edge. Inputs change on the falling edge as well.
module tb_delta_calc_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [47:0] target_angle_flat;
  logic [47:0] current_angle_flat;
  logic        calc_enable;
  logic [11:0] calc_target;
  logic [11:0] calc_current;
  logic [11:0] calc_delta;
  logic        calc_dir;
  logic        calc_updated;
  logic [3:0]  grant_done;
  logic [11:0] result_delta;
  logic        result_dir;
  logic        result_err;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  // Calculator model controls
  bit          model_en      = 1'b1;
  int          model_latency = 6;
  logic [11:0] model_delta   = 12'd0;
  logic        model_dir     = 1'b0;

  delta_calc_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clock              (clock),
    .reset              (reset),
    .req                (req),
    .target_angle_flat  (target_angle_flat),
    .current_angle_flat (current_angle_flat),
    .calc_enable        (calc_enable),
    .calc_target        (calc_target),
    .calc_current       (calc_current),
    .calc_delta         (calc_delta),
    .calc_dir           (calc_dir),
    .calc_updated       (calc_updated),
    .grant_done         (grant_done),
    .result_delta       (result_delta),
    .result_dir         (result_dir),
    .result_err         (result_err),
    .busy               (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // The standard calculator raises calc_updated 6 cycles after the calc_enable cycle.
  initial begin
    calc_updated = 1'b0;
    calc_delta   = 12'd0;
    calc_dir     = 1'b0;
    forever begin
      @(negedge clock);
      if (calc_enable === 1'b1 && model_en) begin
        repeat (model_latency) @(negedge clock);
        calc_updated = 1'b1;
        calc_delta   = model_delta;
        calc_dir     = model_dir;
        @(negedge clock);
        calc_updated = 1'b0;
      end
    end
  end

  task automatic wait_enable(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      n++;
      if (calc_enable === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_grant(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      n++;
      if (grant_done !== 4'd0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'd0;
    repeat (2) @(negedge clock);
    compared++;
    if ({calc_enable, grant_done, busy, result_delta, result_dir, result_err,
         calc_target, calc_current} !== 43'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {calc_enable, grant_done, busy, result_delta, result_dir, result_err,
                calc_target, calc_current});
    end
    reset = 1'b0;
    @(negedge clock);
    compared++;
    if (busy !== 1'b0 || grant_done !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_idle: busy=%b grant=%b expected busy=0 grant=0", busy, grant_done);
    end
  endtask

  task automatic test_round_robin();
    int n;
    bit ok;
    logic [3:0] exp_grant;
    logic [11:0] exp_tgt;
    target_angle_flat  = {12'd400, 12'd300, 12'd200, 12'd100};
    current_angle_flat = {12'd40, 12'd30, 12'd20, 12'd10};
    model_en = 1'b1; model_latency = 6; model_delta = 12'd7; model_dir = 1'b0;
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_grant = 4'b0001 << (j % 4);
      exp_tgt   = 12'(100 * ((j % 4) + 1));
      wait_enable(n, ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL rr_enable_%0d: no calc_enable within bound", j);
      end
      if (j > 0) begin
        compared++;
        if (n !== 2) begin
          mismatched++;
          $display("FAIL rr_back_to_back_%0d: gap=%0d expected 2", j, n);
        end
      end
      compared++;
      if (calc_target !== exp_tgt) begin
        mismatched++;
        $display("FAIL rr_target_%0d: got %0d expected %0d", j, calc_target, exp_tgt);
      end
      wait_grant(n, ok);
      compared++;
      if (!ok || grant_done !== exp_grant || n !== 7) begin
        mismatched++;
        $display("FAIL rr_grant_%0d: got %b after %0d expected %b after 7",
                 j, grant_done, n, exp_grant);
      end
      if (j == 4) req = 4'd0;
    end
    @(negedge clock);
  endtask

  task automatic test_single();
    int n;
    bit ok;
    model_latency = 6; model_delta = 12'd50; model_dir = 1'b1;
    target_angle_flat  = {36'd0, 12'd100};
    current_angle_flat = {36'd0, 12'd50};
    req = 4'b0001;
    @(negedge clock);
    compared++;
    if (calc_enable !== 1'b1 || busy !== 1'b1 || calc_target !== 12'd100 ||
        calc_current !== 12'd50) begin
      mismatched++;
      $display("FAIL single_issue: en=%b busy=%b tgt=%0d cur=%0d expected 1 1 100 50",
               calc_enable, busy, calc_target, calc_current);
    end
    req = 4'd0;
    target_angle_flat  = {48{1'b1}};
    current_angle_flat = {48{1'b1}};
    for (int k = 2; k <= 8; k++) begin
      @(negedge clock);
      if (k < 8) begin
        compared++;
        if (grant_done !== 4'd0 || calc_enable !== 1'b0 || calc_target !== 12'd100) begin
          mismatched++;
          $display("FAIL single_wait_%0d: grant=%b en=%b tgt=%0d expected 0 0 100",
                   k, grant_done, calc_enable, calc_target);
        end
      end
    end
    compared++;
    if (grant_done !== 4'b0001 || result_delta !== 12'd50 || result_dir !== 1'b1 ||
        result_err !== 1'b0 || calc_current !== 12'd50) begin
      mismatched++;
      $display("FAIL single_done: grant=%b delta=%0d dir=%b err=%b expected 0001 50 1 0",
               grant_done, result_delta, result_dir, result_err);
    end
    @(negedge clock);
    compared++;
    if (grant_done !== 4'd0 || busy !== 1'b0 || result_delta !== 12'd50) begin
      mismatched++;
      $display("FAIL single_after: grant=%b busy=%b delta=%0d expected 0 0 50",
               grant_done, busy, result_delta);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    model_en = 1'b0;
    target_angle_flat = {12'd0, 12'd999, 24'd0};
    req = 4'b0100;
    wait_enable(n, ok);
    req = 4'd0;
    compared++;
    if (!ok || calc_target !== 12'd999) begin
      mismatched++;
      $display("FAIL timeout_issue: tgt=%0d expected 999", calc_target);
    end
    wait_grant(n, ok);
    compared++;
    if (!ok || n !== 17 || grant_done !== 4'b0100 || result_err !== 1'b1 ||
        result_delta !== 12'd0 || result_dir !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_done: grant=%b after %0d err=%b delta=%0d expected 0100 after 17 1 0",
               grant_done, n, result_err, result_delta);
    end
    @(negedge clock);
    model_en = 1'b1;
  endtask

  task automatic test_simultaneous();
    int n;
    bit ok;
    model_latency = 16; model_delta = 12'hABC; model_dir = 1'b1;
    req = 4'b1000;
    wait_enable(n, ok);
    repeat (3) @(negedge clock);
    req = 4'd0;
    wait_grant(n, ok);
    compared++;
    if (!ok || n !== 14 || grant_done !== 4'b1000 || result_err !== 1'b0 ||
        result_delta !== 12'hABC || result_dir !== 1'b1) begin
      mismatched++;
      $display("FAIL coincident_done: grant=%b after %0d err=%b delta=%0h expected 1000 after 14 0 abc",
               grant_done, n, result_err, result_delta);
    end
    @(negedge clock);
    model_latency = 6;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit ok;
    model_delta = 12'h123; model_dir = 1'b1;
    target_angle_flat = {12'd444, 12'd333, 12'd222, 12'd111};
    req = 4'b0100;
    wait_enable(n, ok);
    req = 4'd0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      compared++;
      if ({calc_enable, grant_done, busy, result_delta, result_dir, result_err,
           calc_target, calc_current} !== 43'd0) begin
        mismatched++;
        $display("FAIL reset_mid_wait_%0d: got %0h expected 0", k,
                 {calc_enable, grant_done, busy, result_delta, result_dir, result_err,
                  calc_target, calc_current});
      end
      @(negedge clock);
    end
    req = 4'b0011;
    wait_enable(n, ok);
    compared++;
    if (!ok || calc_target !== 12'd111) begin
      mismatched++;
      $display("FAIL post_reset_target: tgt=%0d expected 111", calc_target);
    end
    wait_grant(n, ok);
    req = 4'd0;
    compared++;
    if (!ok || grant_done !== 4'b0001) begin
      mismatched++;
      $display("FAIL post_reset_grant: got %b expected 0001", grant_done);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    req = 4'd0;
    target_angle_flat = 48'd0;
    current_angle_flat = 48'd0;
    @(negedge clock);
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
